fir_mac_sequencer: RTL and testbench

//   Time-multiplexed FIR controller. It owns the sample delay line and the

---
 rtl/fir_mac_sequencer_if.sv | 50 +++++
 rtl/fir_mac_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_sequencer_if.sv
// Handshake and configuration bundle for fir_mac_sequencer.
// master: the side that feeds samples/coefficients and consumes results.
// slave : the FIR controller itself.
interface fir_mac_sequencer_if #(
  parameter int N_TAPS  = 10,
  parameter int BW_in   = 4,
  parameter int BW_coef = 4,
  parameter int BW_out  = 8
);

  localparam int IDX_W = $clog2(N_TAPS);

  // Coefficient write port
  logic                      cfg_we;
  logic [IDX_W-1:0]          cfg_addr;
  logic signed [BW_coef-1:0] cfg_data;

  // Input sample stream
  logic                      x_valid;
  logic                      x_ready;
  logic signed [BW_in-1:0]   x_data;

  // Output sample stream
  logic                      y_valid;
  logic                      y_ready;
  logic [BW_out-1:0]         y_data;
  logic                      y_sat;

  // Status
  logic                      busy;

  modport master (
    output cfg_we, cfg_addr, cfg_data,
    output x_valid, x_data,
    input  x_ready,
    input  y_valid, y_data, y_sat,
    output y_ready,
    input  busy
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data,
    input  x_valid, x_data,
    output x_ready,
    output y_valid, y_data, y_sat,
    input  y_ready,
    output busy
  );

endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: owns the sample delay line and the
// coefficient bank and runs every tap through one shared signed MAC.
// One sample is accepted per valid/ready handshake in IDLE; after all taps
// have been accumulated the filtered result is held in DONE until taken.
// Build option: define FIR_MAC_SAT_EN to clamp the output to the signed
// BW_out range (y_sat flags a clamp); otherwise the output wraps and y_sat=0.
module fir_mac_sequencer #(
  parameter int N_TAPS  = 10,
  parameter int BW_in   = 4,
  parameter int BW_coef = 4,
  parameter int BW_out  = 8
) (
  input  logic               clk,
  input  logic               reset,
  fir_mac_sequencer_if.slave bus
);

  localparam int IDX_W = $clog2(N_TAPS);
  localparam int CNT_W = $clog2(N_TAPS + 1);
  localparam int PRD_W = BW_in + BW_coef;
  localparam int BW_acc = BW_in + BW_coef + $clog2(N_TAPS);
  localparam int unsigned NT = N_TAPS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TAPS);
  localparam logic [IDX_W:0]   ADDR_LIM = (IDX_W + 1)'(N_TAPS);

`ifdef FIR_MAC_SAT_EN
  localparam logic signed [BW_acc-1:0] SAT_HI = BW_acc'((2 ** (BW_out - 1)) - 1);
  localparam logic signed [BW_acc-1:0] SAT_LO = BW_acc'(-(2 ** (BW_out - 1)));
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_n;

  // Storage
  logic signed [BW_in-1:0]   x_dl [N_TAPS];
  logic signed [BW_coef-1:0] coef [N_TAPS];

  // Shared MAC datapath
  logic [CNT_W-1:0]         cnt;
  logic [IDX_W-1:0]         tap;
  logic signed [PRD_W-1:0]  prod, prod_n;
  logic signed [BW_acc-1:0] acc, acc_new;

  // Registered output
  logic [BW_out-1:0] y_data_q, y_data_n;
  logic              y_sat_q, y_sat_n;

  // Control strobes
  logic accept;
  logic cfg_commit;
  logic mac_step;
  logic mac_last;
  logic addr_ok;

  assign addr_ok = ({1'b0, bus.cfg_addr} < ADDR_LIM);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic and control strobes
  always_comb begin
    state_n    = state;
    accept     = 1'b0;
    cfg_commit = 1'b0;
    mac_step   = 1'b0;
    mac_last   = 1'b0;
    unique case (state)
      S_IDLE: begin
        cfg_commit = bus.cfg_we && addr_ok;
        accept     = bus.x_valid;
        if (bus.x_valid) begin
          state_n = S_MAC;
        end
      end
      S_MAC: begin
        mac_step = 1'b1;
        if (cnt == CNT_LAST) begin
          mac_last = 1'b1;
          state_n  = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.y_ready) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // The product is registered before accumulation, so MAC spans N_TAPS+1
  // cycles: cnt=k forms tap k's product while tap k-1's is added; the
  // extra cnt=N_TAPS cycle only adds the final product.
  always_comb begin
    tap = cnt[IDX_W-1:0];
    if (cnt == CNT_LAST) begin
      tap = '0;
    end
    prod_n = PRD_W'(x_dl[tap]) * PRD_W'(coef[tap]);
    if (cnt == CNT_LAST) begin
      prod_n = '0;
    end
    acc_new = acc + BW_acc'(prod);
  end

  // Output formatting of the final accumulator value
  always_comb begin
    y_data_n = acc_new[BW_out-1:0];
    y_sat_n  = 1'b0;
`ifdef FIR_MAC_SAT_EN
    if (acc_new > SAT_HI) begin
      y_data_n = SAT_HI[BW_out-1:0];
      y_sat_n  = 1'b1;
    end else if (acc_new < SAT_LO) begin
      y_data_n = SAT_LO[BW_out-1:0];
      y_sat_n  = 1'b1;
    end
`endif
  end

  // Coefficient bank: writes land only in IDLE and only for valid indices
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NT; i++) begin
        coef[i] <= '0;
      end
    end else if (cfg_commit) begin
      coef[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  // Delay line: shifts once per accepted sample, newest at x_dl[0]
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NT; i++) begin
        x_dl[i] <= '0;
      end
    end else if (accept) begin
      x_dl[0] <= bus.x_data;
      for (int unsigned i = 1; i < NT; i++) begin
        x_dl[i] <= x_dl[i-1];
      end
    end
  end

  // MAC sequencing: clear on accept, one tap per cycle while in MAC
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      prod <= '0;
      acc  <= '0;
    end else if (accept) begin
      cnt  <= '0;
      prod <= '0;
      acc  <= '0;
    end else if (mac_step) begin
      acc  <= acc_new;
      prod <= prod_n;
      if (!mac_last) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Output register: loaded as MAC finishes, held through DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      y_data_q <= '0;
      y_sat_q  <= 1'b0;
    end else if (mac_last) begin
      y_data_q <= y_data_n;
      y_sat_q  <= y_sat_n;
    end
  end

  assign bus.x_ready = (state == S_IDLE);
  assign bus.y_valid = (state == S_DONE);
  assign bus.busy    = (state != S_IDLE);
  assign bus.y_data  = y_data_q;
  assign bus.y_sat   = y_sat_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer (default parameters).
// Stimulus pushes hand-computed results; an independent monitor pops and
// compares on every output handshake.
module tb_fir_mac_sequencer;

  logic clk;
  logic reset;

  int tests_run;
  int tests_failed;
  int out_idx;

  logic [8:0] sb[$];

  fir_mac_sequencer_if #(
    .N_TAPS (10),
    .BW_in  (4),
    .BW_coef(4),
    .BW_out (8)
  ) bus ();

  fir_mac_sequencer #(
    .N_TAPS (10),
    .BW_in  (4),
    .BW_coef(4),
    .BW_out (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected {y_sat, y_data} for an exact accumulator value v
  function automatic logic [8:0] expect_out(input int v);
`ifdef FIR_MAC_SAT_EN
    if (v > 127) return {1'b1, 8'h7F};
    if (v < -128) return {1'b1, 8'h80};
`endif
    return {1'b0, 8'(v)};
  endfunction

  // Monitor: every output handshake consumes one expected value
  always @(negedge clk) begin
    if (!reset && bus.y_valid && bus.y_ready) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL y_unexpected: got 0x%0h expected no output", {bus.y_sat, bus.y_data});
      end else begin
        check($sformatf("y_out[%0d]", out_idx), 32'({bus.y_sat, bus.y_data}), 32'(sb.pop_front()));
      end
      out_idx++;
    end
  end

  task automatic do_reset();
    reset       = 1'b1;
    bus.cfg_we  = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.x_valid = 1'b0;
    bus.x_data  = '0;
    bus.y_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Wait (bounded) until all expected outputs are seen and the DUT is idle
  task automatic drain();
    int unsigned guard;
    guard = 0;
    while ((sb.size() != 0 || !bus.x_ready) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int unsigned guard;
    guard = 0;
    @(negedge clk);
    while (!bus.x_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.x_ready) check(name, 32'd0, 32'd1);
  endtask

  task automatic write_coef(input logic [3:0] addr, input logic [3:0] data);
    wait_idle("cfg_idle_timeout");
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    @(posedge clk);
    #1 bus.cfg_we = 1'b0;
  endtask

  task automatic send_sample(input logic [3:0] xv);
    wait_idle("x_accept_timeout");
    bus.x_valid = 1'b1;
    bus.x_data  = xv;
    @(posedge clk);
    #1 bus.x_valid = 1'b0;
  endtask

  initial begin
    int lat;
    int yv_cnt;
    tests_run    = 0;
    tests_failed = 0;
    out_idx      = 0;

    // 1. Reset values and latency with all-zero coefficients
    do_reset();
    @(negedge clk);
    check("rst_x_ready", 32'(bus.x_ready), 32'd1);
    check("rst_y_valid", 32'(bus.y_valid), 32'd0);
    check("rst_y_data",  32'(bus.y_data),  32'd0);
    check("rst_y_sat",   32'(bus.y_sat),   32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    sb.push_back(expect_out(0));
    send_sample(4'd5);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.y_valid) break;
    end
    check("latency", 32'(lat), 32'd11);
    drain();

    // 2. Impulse response with c[k] = k-4
    do_reset();
    for (int k = 0; k < 10; k++) write_coef(4'(k), 4'(k - 4));
    for (int k = 0; k < 10; k++) begin
      sb.push_back(expect_out(k - 4));
      send_sample((k == 0) ? 4'd1 : 4'd0);
    end
    drain();

    // 3. Backpressure in DONE with a pending sample
    do_reset();
    write_coef(4'd0, 4'd3);
    bus.y_ready = 1'b0;
    sb.push_back(expect_out(6));
    send_sample(4'd2);
    bus.x_valid = 1'b1;
    bus.x_data  = 4'd1;
    sb.push_back(expect_out(3));
    lat = 0;
    @(negedge clk);
    while (!bus.y_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_y_valid", 32'(bus.y_valid), 32'd1);
      check("bp_y_data",  32'(bus.y_data),  32'h06);
      check("bp_x_ready", 32'(bus.x_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.y_ready = 1'b1;
    @(posedge clk);               // y handshake edge
    @(negedge clk);
    check("bp_not_yet_accepted", 32'(bus.busy), 32'd0);
    @(posedge clk);               // pending sample accepted here
    #1 bus.x_valid = 1'b0;
    @(negedge clk);
    check("bp_accepted", 32'(bus.busy), 32'd1);
    drain();

    // 4. Large accumulation: all c=7, ten samples of 7
    do_reset();
    for (int k = 0; k < 10; k++) write_coef(4'(k), 4'd7);
    for (int k = 1; k <= 10; k++) begin
      sb.push_back(expect_out(49 * k));
      send_sample(4'd7);
    end
    drain();
`ifdef FIR_MAC_SAT_EN
    check("sat_const", 32'(expect_out(490)), 32'h17F);
`else
    check("wrap_const", 32'(expect_out(490)), 32'h0EA);
`endif

    // 5. Reset during MAC discards the computation and clears the delay line
    do_reset();
    write_coef(4'd0, 4'd1);
    write_coef(4'd1, 4'd1);
    send_sample(4'd3);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    yv_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.y_valid) yv_cnt++;
    end
    check("abort_no_y_valid", 32'(yv_cnt), 32'd0);
    write_coef(4'd0, 4'd3);
    write_coef(4'd1, 4'd5);
    sb.push_back(expect_out(3));
    send_sample(4'd1);
    sb.push_back(expect_out(5));
    send_sample(4'd0);
    drain();

    // 6. Config corner cases
    do_reset();
    write_coef(4'd0, 4'd1);
    sb.push_back(expect_out(1));
    send_sample(4'd1);
    @(posedge clk);
    #1;
    bus.cfg_we   = 1'b1;         // lands while busy: ignored
    bus.cfg_addr = 4'd0;
    bus.cfg_data = 4'hE;
    @(posedge clk);
    #1 bus.cfg_we = 1'b0;
    sb.push_back(expect_out(2));
    send_sample(4'd2);
    write_coef(4'd12, 4'd5);      // out-of-range index: ignored
    sb.push_back(expect_out(3));
    send_sample(4'd3);
    drain();

    do_reset();
    wait_idle("same_edge_idle");
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'd0;
    bus.cfg_data = 4'd2;
    bus.x_valid  = 1'b1;
    bus.x_data   = 4'd1;
    sb.push_back(expect_out(2));
    @(posedge clk);
    #1;
    bus.cfg_we  = 1'b0;
    bus.x_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
